// File: rtl/deserializer_pkg.sv
// Shared definitions for the SPI-side frame receiver: field-width defaults,
// opcode encodings and the clog2 helper also used by the serializer.
package deserializer_pkg;

    localparam int ADDRW_DEF   = 8;
    localparam int OPCODEW_DEF = 2;
    localparam int SYNC_DEF    = 2;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;
    localparam logic [1:0] OP_CTRL  = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/deserializer_if.sv
// Frame receiver bus: asynchronous SPI pins in, one-deep frame handshake out.
interface deserializer_if
    import deserializer_pkg::*;
#(
    parameter int ADDRW   = ADDRW_DEF,
    parameter int OPCODEW = OPCODEW_DEF
) ();

    logic               n_cs;
    logic               spi_clk;
    logic               mosi;
    logic               ready_in;
    logic               valid_out;
    logic [OPCODEW-1:0] opcode;
    logic [ADDRW-1:0]   addr;
    logic               overrun;

    modport master (
        input  n_cs, spi_clk, mosi, ready_in,
        output valid_out, opcode, addr, overrun
    );

    modport slave (
        output n_cs, spi_clk, mosi, ready_in,
        input  valid_out, opcode, addr, overrun
    );

endinterface

// File: rtl/deserializer_sync_edge_det.sv
// SYNC-deep synchronizer with one extra history flop producing single-clk
// rise/fall pulses on the synchronized signal.
module deserializer_sync_edge_det #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC-1:0] r_sync;
    logic            r_prev;

    // Synchronizer chain followed by the previous-value flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], i_d};
            r_prev <= r_sync[SYNC-1];
        end
    end

    assign o_q    = r_sync[SYNC-1];
    assign o_rise = !r_prev &&  r_sync[SYNC-1];
    assign o_fall =  r_prev && !r_sync[SYNC-1];

endmodule

// File: rtl/deserializer.sv
// SPI receiver: samples MOSI on synchronized rising spi_clk while n_cs is low,
// assembles MSB-first {opcode, addr} frames and offers them over valid/ready.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int ADDRW   = ADDRW_DEF,
    parameter int OPCODEW = OPCODEW_DEF,
    parameter int SYNC    = SYNC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    deserializer_if.master bus
);

    localparam int SHIFT_W = OPCODEW + ADDRW;
    localparam int CNT_W   = clog2(SHIFT_W);

    logic [SYNC-1:0]    r_ncs_sync;
    logic [SYNC-1:0]    r_mosi_sync;
    logic [SHIFT_W-2:0] r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_valid;
    logic [OPCODEW-1:0] r_opcode;
    logic [ADDRW-1:0]   r_addr;
    logic               r_overrun;

    logic               w_spi_rise;
    logic               w_spi_q_unused;
    logic               w_spi_fall_unused;
    logic               w_cs_act;
    logic               w_mosi_s;
    logic               w_shift;
    logic               w_done;
    logic               w_load;
    logic [SHIFT_W-1:0] w_word;

    deserializer_sync_edge_det #(.SYNC(SYNC)) u_spi_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.spi_clk),
        .o_q    (w_spi_q_unused),
        .o_rise (w_spi_rise),
        .o_fall (w_spi_fall_unused)
    );

    // Same depth as the spi_clk chain so data and select line up with the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ncs_sync  <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_ncs_sync  <= {r_ncs_sync[SYNC-2:0], bus.n_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC-2:0], bus.mosi};
        end
    end

    assign w_cs_act = !r_ncs_sync[SYNC-1];
    assign w_mosi_s = r_mosi_sync[SYNC-1];
    assign w_shift  = w_spi_rise && w_cs_act;
    assign w_done   = w_shift && (r_cnt == CNT_W'(SHIFT_W - 1));
    assign w_word   = {r_shreg, w_mosi_s};
    assign w_load   = w_done && (!r_valid || bus.ready_in);

    // Shift register and bit counter; deselect abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (!w_cs_act) begin
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_shreg <= w_word[SHIFT_W-2:0];
            r_cnt   <= w_done ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Output register: a completion may refill it in the same cycle it is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_opcode  <= '0;
            r_addr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid  <= 1'b1;
                r_opcode <= w_word[SHIFT_W-1:ADDRW];
                r_addr   <= w_word[ADDRW-1:0];
            end else if (r_valid && bus.ready_in) begin
                r_valid  <= 1'b0;
            end
            r_overrun <= w_done && r_valid && !bus.ready_in;
        end
    end

    assign bus.valid_out = r_valid;
    assign bus.opcode    = r_opcode;
    assign bus.addr      = r_addr;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for the SPI frame receiver at f_spi = f_clk/8.
module tb_deserializer;
    import deserializer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    deserializer_if bus ();

    deserializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_tests  = 0;
    int         n_fails  = 0;
    int         ov_cnt   = 0;
    int         gap_cnt  = 0;
    bit         watch_gap = 1'b0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every transfer pops the oldest expected frame and compares it.
    task automatic monitor();
        logic [9:0] e;
        if (!rst) begin
            if (bus.overrun) ov_cnt++;
            if (watch_gap && exp_q.size() > 0 && !bus.valid_out) gap_cnt++;
            if (bus.valid_out && bus.ready_in) begin
                check("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("opcode", {30'd0, bus.opcode}, {30'd0, e[9:8]});
                    check("addr", {24'd0, bus.addr}, {24'd0, e[7:0]});
                end
            end
        end
    endtask

    always @(negedge clk) monitor();

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // One SPI bit: 4 clk low, 4 clk high; optional ready_in in the completion cycle.
    task automatic spi_bit(input logic b, input bit rdy);
        bus.spi_clk = 1'b0;
        bus.mosi    = b;
        repeat (4) @(posedge clk);
        #1;
        bus.spi_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (rdy) bus.ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.spi_clk = 1'b0;
    endtask

    task automatic send_frame(input logic [9:0] w, input int nbits, input bit rdy_last);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(w[9-i], rdy_last && (i == nbits - 1));
        end
    endtask

    task automatic cs_low();
        align();
        bus.n_cs = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cs_high();
        align();
        bus.n_cs = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 80 && exp_q.size() > 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0;
        bus.n_cs     = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.mosi     = 1'b0;
        bus.ready_in = 1'b0;
        rst          = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", bus.valid_out, 32'd0);
        check("rst_opcode", {30'd0, bus.opcode}, 32'd0);
        check("rst_addr", {24'd0, bus.addr}, 32'd0);
        check("rst_overrun", bus.overrun, 32'd0);

        // Test 1: single frame, always ready.
        align();
        bus.ready_in = 1'b1;
        ov0 = ov_cnt;
        cs_low();
        exp_q.push_back(10'h2A5);
        send_frame(10'h2A5, 10, 1'b0);
        wait_drain("t1_drain");
        check("t1_valid_low", bus.valid_out, 32'd0);
        check("t1_overrun", ov_cnt - ov0, 32'd0);
        cs_high();

        // Test 2: frame held while downstream stalls.
        bus.ready_in = 1'b0;
        cs_low();
        exp_q.push_back(10'h1C3);
        send_frame(10'h1C3, 10, 1'b0);
        repeat (20) @(negedge clk);
        check("t2_held_valid", bus.valid_out, 32'd1);
        check("t2_held_opcode", {30'd0, bus.opcode}, 32'd1);
        check("t2_held_addr", {24'd0, bus.addr}, 32'hC3);
        align();
        bus.ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_drop", bus.valid_out, 32'd0);
        check("t2_queue", exp_q.size(), 32'd0);
        cs_high();

        // Test 3: second frame arrives while the first is still held.
        bus.ready_in = 1'b0;
        ov0 = ov_cnt;
        cs_low();
        exp_q.push_back(10'h1C3);
        send_frame(10'h1C3, 10, 1'b0);
        send_frame(10'h2FF, 10, 1'b0);
        repeat (10) @(negedge clk);
        check("t3_overrun", ov_cnt - ov0, 32'd1);
        check("t3_valid", bus.valid_out, 32'd1);
        check("t3_opcode", {30'd0, bus.opcode}, 32'd1);
        check("t3_addr", {24'd0, bus.addr}, 32'hC3);
        align();
        bus.ready_in = 1'b1;
        wait_drain("t3_drain");
        check("t3_valid_low", bus.valid_out, 32'd0);
        cs_high();

        // Test 4: partial frame abandoned by deselect.
        ov0 = ov_cnt;
        cs_low();
        send_frame(10'h2C0, 5, 1'b0);
        cs_high();
        cs_low();
        exp_q.push_back(10'h3AA);
        send_frame(10'h3AA, 10, 1'b0);
        wait_drain("t4_drain");
        check("t4_overrun", ov_cnt - ov0, 32'd0);
        cs_high();

        // Test 5: back-to-back frames, ready on the second completion cycle.
        bus.ready_in = 1'b0;
        ov0 = ov_cnt;
        gap_cnt = 0;
        cs_low();
        exp_q.push_back(10'h15A);
        exp_q.push_back(10'h0F0);
        send_frame(10'h15A, 10, 1'b0);
        for (int i = 0; i < 20 && !bus.valid_out; i++) @(negedge clk);
        check("t5_first_valid", bus.valid_out, 32'd1);
        watch_gap = 1'b1;
        send_frame(10'h0F0, 10, 1'b1);
        wait_drain("t5_drain");
        watch_gap = 1'b0;
        check("t5_no_bubble", gap_cnt, 32'd0);
        check("t5_overrun", ov_cnt - ov0, 32'd0);
        check("t5_valid_low", bus.valid_out, 32'd0);
        cs_high();

        // Test 6: reset mid-frame with a frame held; the held frame is lost.
        bus.ready_in = 1'b0;
        ov0 = ov_cnt;
        cs_low();
        send_frame(10'h2FF, 10, 1'b0);
        send_frame(10'h3FF, 6, 1'b0);
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", bus.valid_out, 32'd0);
        check("t6_opcode", {30'd0, bus.opcode}, 32'd0);
        check("t6_addr", {24'd0, bus.addr}, 32'd0);
        check("t6_overrun", bus.overrun, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        bus.ready_in = 1'b1;
        exp_q.push_back(10'h055);
        send_frame(10'h055, 10, 1'b0);
        wait_drain("t6_drain");
        check("t6_no_overrun", ov_cnt - ov0, 32'd0);
        cs_high();

        check("final_queue", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
